// File: rtl/uart_rx_deser_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, frame
// width and the baud divisor helper that the transmit side will reuse.
package uart_rx_deser_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Core clocks per serial bit; integer division, callers keep the result >= 4.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO between the receiver and the MMIO read path.
// Pointers carry an extra wrap bit so full and empty are told apart without a
// separate counter. The head entry is read straight from storage (no
// fall-through), and storage is cleared on reset so rdata is never X.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO only lands when the head is popped in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 serial receiver: synchronizes the raw line, finds the start edge, samples
// each bit near its midpoint with a baud counter, and queues good bytes in a
// small FIFO. Framing errors and FIFO overruns are reported as 1-cycle pulses.
module uart_rx_deser
  import uart_rx_deser_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

  rx_state_e                 state_q, state_d;
  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      busy_q, busy_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      rxs;
  logic                      expired;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign rxs       = sync2_q;
  assign expired   = (cnt_q == '0);
  assign rvalid    = !fifo_empty;
  assign fifo_pop  = rready && rvalid;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // Next-state logic for the synchronizer, baud counter, bit index, shifter and FSM.
  always_comb begin
    sync1_d     = uart_rx;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    fifo_push   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_d   = HALF_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxs) begin
          idx_d   = '0;
          cnt_d   = FULL_LOAD;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[idx_q] = rxs;
          cnt_d          = FULL_LOAD;
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs) begin
          fifo_push = 1'b1;
          overrun_d = fifo_full && !fifo_pop;
          state_d   = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Receiver registers; the synchronizer resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (shift_q),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .rdata (rdata),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at 8 clocks per bit. Inputs change 1 time
// unit after a rising edge and outputs are read there too; flag pulses and
// pops are recorded on the falling edge.
module tb_uart_rx_deser;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] pop_log[$];

  uart_rx_deser #(
    .CLK_FREQ   (8),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record flag pulse cycles and every byte handed over by a pop.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (rvalid === 1'b1 && rready === 1'b1) pop_log.push_back(rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (8) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_rx = 1'b1; rready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalid); end
    n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("[TB] FAIL reset_rdata: got %h want 00", rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_flags: got fe=%b ov=%b want 0/0", frame_err, overrun);
    end
    repeat (4) step();
  endtask

  task automatic test_single();
    logic [9:0] f;
    f = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 9; i++) begin
      uart_rx = f[i];
      repeat (8) step();
      if (i == 0) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
      end
    end
    uart_rx = 1'b1;
    repeat (6) step();
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL single_rvalid_early: got %b want 0", rvalid); end
    step();
    n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("[TB] FAIL single_rvalid_rise: got %b want 1", rvalid); end
    n_cmp++; if (rdata !== 8'hA5) begin n_err++; $display("[TB] FAIL single_rdata: got %h want a5", rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_busy_end: got %b want 0", busy); end
    step();
    rready = 1'b1;
    step();
    rready = 1'b0;
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL single_pop_rvalid: got %b want 0", rvalid); end
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    int base;
    int fe0;
    int ov0;
    exp_b = '{8'h00, 8'hFF, 8'h55};
    base = pop_log.size();
    fe0 = fe_cnt; ov0 = ov_cnt;
    rready = 1'b1;
    for (int k = 0; k < 3; k++) send_frame(exp_b[k]);
    repeat (4) step();
    rready = 1'b0;
    n_cmp++; if (pop_log.size() - base !== 3) begin
      n_err++; $display("[TB] FAIL b2b_count: got %0d want 3", pop_log.size() - base);
    end
    for (int k = 0; k < 3; k++) begin
      if (pop_log.size() > base + k) begin
        n_cmp++; if (pop_log[base + k] !== exp_b[k]) begin
          n_err++; $display("[TB] FAIL b2b_byte%0d: got %h want %h", k, pop_log[base + k], exp_b[k]);
        end
      end
    end
    n_cmp++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      n_err++; $display("[TB] FAIL b2b_flags: got fe=%0d ov=%0d want 0/0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_glitch();
    int fe0;
    int ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    uart_rx = 1'b0;
    repeat (3) step();
    uart_rx = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL glitch_busy_rise: got %b want 1", busy); end
    repeat (12) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL glitch_busy_fall: got %b want 0", busy); end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL glitch_rvalid: got %b want 0", rvalid); end
    n_cmp++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      n_err++; $display("[TB] FAIL glitch_flags: got fe=%0d ov=%0d want 0/0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_frame_err();
    logic [8:0] f;
    int fe0;
    f = {8'h3C, 1'b0};
    fe0 = fe_cnt;
    for (int i = 0; i < 9; i++) begin
      uart_rx = f[i];
      repeat (8) step();
    end
    uart_rx = 1'b0;
    repeat (16) step();
    uart_rx = 1'b1;
    repeat (8) step();
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("[TB] FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL ferr_rvalid: got %b want 0", rvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL ferr_busy: got %b want 0", busy); end
    send_frame(8'h42);
    n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("[TB] FAIL ferr_next_rvalid: got %b want 1", rvalid); end
    n_cmp++; if (rdata !== 8'h42) begin n_err++; $display("[TB] FAIL ferr_next_rdata: got %h want 42", rdata); end
    rready = 1'b1;
    step();
    rready = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    for (int k = 1; k <= 4; k++) send_frame(8'(k));
    n_cmp++; if (ov_cnt - ov0 !== 0) begin n_err++; $display("[TB] FAIL ovr_early: got %0d want 0", ov_cnt - ov0); end
    send_frame(8'h05);
    n_cmp++; if (ov_cnt - ov0 !== 1) begin n_err++; $display("[TB] FAIL ovr_pulses: got %0d want 1", ov_cnt - ov0); end
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (rvalid !== 1'b1 || rdata !== 8'(k)) begin
        n_err++; $display("[TB] FAIL ovr_drain%0d: got v=%b d=%h want 1/%h", k, rvalid, rdata, 8'(k));
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
    end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL ovr_empty: got %b want 0", rvalid); end
    repeat (2) step();
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] f;
    int fe0;
    int ov0;
    send_frame(8'h77);
    n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_preload: got %b want 1", rvalid); end
    fe0 = fe_cnt; ov0 = ov_cnt;
    f = {8'hF0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      uart_rx = f[i];
      repeat (8) step();
    end
    uart_rx = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_rvalid: got %b want 0", rvalid); end
    repeat (40) step();
    n_cmp++; if (rvalid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL rmid_after: got v=%b busy=%b want 0/0", rvalid, busy);
    end
    n_cmp++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      n_err++; $display("[TB] FAIL rmid_flags: got fe=%0d ov=%0d want 0/0", fe_cnt - fe0, ov_cnt - ov0);
    end
    send_frame(8'h99);
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 8'h99) begin
      n_err++; $display("[TB] FAIL rmid_recover: got v=%b d=%h want 1/99", rvalid, rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    rready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
